// File: rtl/uart_phy_if.sv
// uart_phy_if: stream-side handshake bundle for uart_phy.
//   master modport : the stream user (APB register block / testbench)
//   slave  modport : the PHY itself
// Signals:
//   tx_data/tx_valid -> PHY, tx_ready <- PHY      transmit byte stream
//   rx_data/rx_valid <- PHY, rx_ready -> PHY      receive byte stream
//   rx_frame_err/rx_parity_err <- PHY             qualified by rx_valid
//   rx_overrun <- PHY                             one-cycle drop pulse
interface uart_phy_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_frame_err;
  logic              rx_parity_err;
  logic              rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_phy.sv
// uart_phy: parametrised UART transmitter/receiver.
//   Bit period T = OVS*(baud_div+1) PCLK cycles; baud_div, stop2 and parity
//   settings are captured at the start of each frame.
// Ports:
//   PCLK, PRESETn   clock, async active-low reset
//   baud_div        PCLK cycles per oversample tick, minus 1
//   stop2           0: one stop bit, 1: two stop bits
//   parity_en/odd   parity control (only with UART_PHY_PARITY_EN defined)
//   bus             stream side handshakes (uart_phy_if.slave)
//   Tx              serial output, idles high
//   RX              serial input, asynchronous
// Configuration macro: UART_PHY_PARITY_EN enables the parity bit and the
// parity_en/parity_odd ports; without it the parity path is unreachable and
// rx_parity_err stays 0.
module uart_phy #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
`ifdef UART_PHY_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  uart_phy_if.slave        bus,
  output logic             Tx,
  input  logic             RX
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic cfg_pen, cfg_podd;
`ifdef UART_PHY_PARITY_EN
  assign cfg_pen  = parity_en;
  assign cfg_podd = parity_odd;
`else
  assign cfg_pen  = 1'b0;
  assign cfg_podd = 1'b0;
`endif

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_e;
  tx_st_e            tst, tst_n;
  logic [DIV_W-1:0]  tpre, tpre_n, tdiv, tdiv_n;
  logic [TW-1:0]     ttick, ttick_n;
  logic [BW-1:0]     tbit, tbit_n;      // data index, or stop index in T_STOP
  logic [DATA_W-1:0] tsh, tsh_n;
  logic              tstop2, tstop2_n, tpen, tpen_n, tpbit, tpbit_n;
  logic              tx_q, tx_n, trdy, trdy_n;
  logic              t_tick, t_end;

  always_comb begin
    tst_n    = tst;
    tpre_n   = tpre;
    ttick_n  = ttick;
    tbit_n   = tbit;
    tsh_n    = tsh;
    tdiv_n   = tdiv;
    tstop2_n = tstop2;
    tpen_n   = tpen;
    tpbit_n  = tpbit;
    tx_n     = tx_q;
    t_tick   = (tpre == tdiv);
    t_end    = t_tick && (ttick == TICK_LAST);
    if (tst != T_IDLE) begin
      tpre_n = t_tick ? '0 : tpre + 1'b1;
      if (t_tick) ttick_n = (ttick == TICK_LAST) ? '0 : ttick + 1'b1;
    end
    case (tst)
      T_START: if (t_end) begin
        tst_n  = T_DATA;
        tbit_n = '0;
        tx_n   = tsh[0];
      end
      T_DATA: if (t_end) begin
        if (tbit == BIT_LAST) begin
          tbit_n = '0;
          if (tpen) begin tst_n = T_PAR;  tx_n = tpbit; end
          else      begin tst_n = T_STOP; tx_n = 1'b1;  end
        end else begin
          tbit_n = tbit + 1'b1;
          tsh_n  = tsh >> 1;
          tx_n   = tsh[1];
        end
      end
      T_PAR: if (t_end) begin
        tst_n = T_STOP;
        tx_n  = 1'b1;
      end
      T_STOP: if (t_end) begin
        if (tstop2 && tbit == '0) tbit_n = BIT_ONE;
        else                      tst_n  = T_IDLE;
      end
      default: ;
    endcase
    // trdy is only high in IDLE or the last stop cycle, so acceptance here
    // overrides the end-of-frame return to IDLE with no idle gap.
    if (bus.tx_valid && trdy) begin
      tst_n    = T_START;
      tpre_n   = '0;
      ttick_n  = '0;
      tsh_n    = bus.tx_data;
      tdiv_n   = baud_div;
      tstop2_n = stop2;
      tpen_n   = cfg_pen;
      tpbit_n  = (^bus.tx_data) ^ cfg_podd;
      tx_n     = 1'b0;
    end
    // Registered ready: look one cycle ahead for the final stop cycle.
    trdy_n = (tst_n == T_IDLE) ||
             (tst_n == T_STOP && (tbit_n == BIT_ONE || !tstop2_n) &&
              tpre_n == tdiv_n && ttick_n == TICK_LAST);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tst    <= T_IDLE;
      tpre   <= '0;
      tdiv   <= '0;
      ttick  <= '0;
      tbit   <= '0;
      tsh    <= '0;
      tstop2 <= 1'b0;
      tpen   <= 1'b0;
      tpbit  <= 1'b0;
      tx_q   <= 1'b1;
      trdy   <= 1'b1;
    end else begin
      tst    <= tst_n;
      tpre   <= tpre_n;
      tdiv   <= tdiv_n;
      ttick  <= ttick_n;
      tbit   <= tbit_n;
      tsh    <= tsh_n;
      tstop2 <= tstop2_n;
      tpen   <= tpen_n;
      tpbit  <= tpbit_n;
      tx_q   <= tx_n;
      trdy   <= trdy_n;
    end
  end

  assign Tx           = tx_q;
  assign bus.tx_ready = trdy;

  // ---------------------------------------------------------------- RX
  // rs1 is the synchronised line; rs2 is its previous value for edge detect.
  logic rs0, rs1, rs2;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rs0 <= 1'b1;
      rs1 <= 1'b1;
      rs2 <= 1'b1;
    end else begin
      rs0 <= RX;
      rs1 <= rs0;
      rs2 <= rs1;
    end
  end

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_e;
  rx_st_e            rxs, rxs_n;
  logic [DIV_W-1:0]  rpre, rpre_n, rdiv, rdiv_n;
  logic [TW-1:0]     rtick, rtick_n;
  logic [BW-1:0]     rbit, rbit_n;
  logic [DATA_W-1:0] rsh, rsh_n;
  logic              rpen, rpen_n, rpodd, rpodd_n, rperr, rperr_n;
  logic              r_tick, r_half, r_full, commit;

  always_comb begin
    rxs_n   = rxs;
    rpre_n  = rpre;
    rdiv_n  = rdiv;
    rtick_n = rtick;
    rbit_n  = rbit;
    rsh_n   = rsh;
    rpen_n  = rpen;
    rpodd_n = rpodd;
    rperr_n = rperr;
    commit  = 1'b0;
    r_tick  = (rpre == rdiv);
    r_half  = r_tick && (rtick == TICK_HALF);
    r_full  = r_tick && (rtick == TICK_LAST);
    if (rxs != R_IDLE) begin
      rpre_n = r_tick ? '0 : rpre + 1'b1;
      if (r_tick) rtick_n = (rtick == TICK_LAST) ? '0 : rtick + 1'b1;
    end
    case (rxs)
      R_IDLE: if (rs2 && !rs1) begin
        rxs_n   = R_START;
        rpre_n  = '0;
        rtick_n = '0;
        rdiv_n  = baud_div;
        rpen_n  = cfg_pen;
        rpodd_n = cfg_podd;
        rperr_n = 1'b0;
      end
      // Mid-start sample; restarting the tick count here puts every later
      // sample in the middle of its bit.
      R_START: if (r_half) begin
        rtick_n = '0;
        rbit_n  = '0;
        rxs_n   = rs1 ? R_IDLE : R_DATA;
      end
      R_DATA: if (r_full) begin
        rsh_n = {rs1, rsh[DATA_W-1:1]};
        if (rbit == BIT_LAST) rxs_n  = rpen ? R_PAR : R_STOP;
        else                  rbit_n = rbit + 1'b1;
      end
      R_PAR: if (r_full) begin
        rperr_n = rs1 ^ (^rsh) ^ rpodd;
        rxs_n   = R_STOP;
      end
      R_STOP: if (r_full) begin
        commit = 1'b1;
        rxs_n  = R_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rxs   <= R_IDLE;
      rpre  <= '0;
      rdiv  <= '0;
      rtick <= '0;
      rbit  <= '0;
      rsh   <= '0;
      rpen  <= 1'b0;
      rpodd <= 1'b0;
      rperr <= 1'b0;
    end else begin
      rxs   <= rxs_n;
      rpre  <= rpre_n;
      rdiv  <= rdiv_n;
      rtick <= rtick_n;
      rbit  <= rbit_n;
      rsh   <= rsh_n;
      rpen  <= rpen_n;
      rpodd <= rpodd_n;
      rperr <= rperr_n;
    end
  end

  // Output holding register; a commit while the old character is still
  // pending (and not being taken this cycle) is dropped and flagged.
  logic [DATA_W-1:0] rd_q;
  logic              rv_q, rferr_q, rperr_q, rovr_q, r_acc;
  assign r_acc = rv_q && bus.rx_ready;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rd_q    <= '0;
      rv_q    <= 1'b0;
      rferr_q <= 1'b0;
      rperr_q <= 1'b0;
      rovr_q  <= 1'b0;
    end else begin
      rovr_q <= commit && rv_q && !r_acc;
      if (commit && (!rv_q || r_acc)) begin
        rd_q    <= rsh;
        rferr_q <= !rs1;
        rperr_q <= rperr;
        rv_q    <= 1'b1;
      end else if (r_acc) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = rd_q;
  assign bus.rx_valid      = rv_q;
  assign bus.rx_frame_err  = rferr_q;
  assign bus.rx_parity_err = rperr_q;
  assign bus.rx_overrun    = rovr_q;
endmodule

// File: doc/uart_phy.md
# uart_phy

Parametrised UART transmitter/receiver pair that converts between valid/ready byte streams and the serial `Tx`/`RX` lines. It generalises the single fixed-format serial link with configurable character width, oversampling, runtime baud divisor, stop-bit count, optional parity, and receive error reporting. It sits between the APB register block (stream side) and the chip pads or testbench serial interface (line side).

## Interface
- `DATA_W`, 8: character width in bits, 5..9.
- `OVS`, 16: oversampling ticks per bit; even, at least 4.
- `DIV_W`, 16: width of `baud_div`.

Ports:
- `PCLK`  in  1  clock. One clock domain; all logic is rising-edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_W  PCLK cycles per oversample tick, minus 1.
- `stop2`  in  1  0 selects 1 stop bit; 1 selects 2 stop bits.
- `parity_en`, `parity_odd`  in  1 each  parity enable and odd-parity select. Present only with the configuration macro.
- `tx_data`  in  DATA_W  character to send.
- `tx_valid`  in  1  transmit request.
- `tx_ready`  out  1  transmitter can accept a character.
- `Tx`  out  1  serial output; idles high.
- `RX`  in  1  serial input; asynchronous.
- `rx_data`  out  DATA_W  received character.
- `rx_valid`  out  1  `rx_data` and the error flags are valid.
- `rx_ready`  in  1  consumer accepts the character.
- `rx_frame_err`, `rx_parity_err`  out  1 each  error flags; qualified by `rx_valid`.
- `rx_overrun`  out  1  one-cycle pulse when a received character is dropped.

## Operation
- **Bit period:** `T = OVS*(baud_div+1)` PCLK cycles.
  - `baud_div`, `stop2` and parity settings are latched at frame start.
  - Changes made mid-frame apply to the next frame.
- **TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.**
  - Handshake: a character is accepted when `tx_valid && tx_ready`.
  - The TX prescaler restarts at acceptance.
  - `Tx` outputs one low start bit, then `DATA_W` data bits LSB first, then the parity bit (if enabled), then 1 or 2 high stop bits.
  - `tx_ready` is 1 in IDLE and in the last cycle of the final stop bit; it is 0 otherwise.
  - Acceptance in that last stop-bit cycle starts the next start bit with no idle gap.
- **RX front end:** a 2-flop synchroniser on `RX`. All RX timing below refers to the synchronised signal.
- **RX FSM: IDLE → START → DATA → PARITY → STOP.**
  - In IDLE, a falling edge restarts the RX prescaler.
  - The start bit is sampled `OVS/2` ticks after the edge. If it is high, this is a false start and the FSM returns to IDLE.
  - Each following bit is sampled every `OVS` ticks.
  - Only the first stop bit is checked. If it samples low, `rx_frame_err` is set.
  - At the stop sample, the character is committed and the FSM returns to IDLE immediately, ready for the next edge.
- **Commit rules:**
  - If `rx_valid` is 0: load `rx_data` and the flags, and set `rx_valid`.
  - If `rx_valid` is 1: pulse `rx_overrun` for one cycle, discard the new character, and hold the old character and flags.
  - A commit that coincides with the `rx_valid && rx_ready` cycle is not an overrun; the new character loads.
- `rx_valid` clears on `rx_valid && rx_ready`.
- A break condition (line held low) reports `rx_data=0` with `rx_frame_err=1`. The receiver then waits for the line to go high, followed by a new falling edge.

## Timing
- Reset values:
  - `Tx=1`, `tx_ready=1`.
  - `rx_valid=0`, `rx_data=0`.
  - All error flags 0.
  - Both FSMs in IDLE; the synchroniser flops set to 1.
- Reset asserted mid-frame aborts both directions. `Tx` goes high asynchronously, and the partial RX character is discarded.
- TX, character accepted at cycle c: the frame occupies cycles c+1 .. c+F·T, where `F = 1+DATA_W+P+S`.
- RX, external falling edge at cycle t:
  - The edge is visible internally at t+2.
  - Sample k (k=0 is the start bit) occurs at t+2+T/2+k·T.
  - `rx_valid` rises one cycle after the stop sample.
- `tx_ready`, `rx_valid` and all flags are registered outputs; there are no combinational input-to-output paths.

## Configuration
- Macro: `UART_PHY_PARITY_EN`.
- **Defined:**
  - `parity_en` and `parity_odd` ports exist.
  - When `parity_en=1`, a parity bit follows the data: even parity gives an even total count of ones over data plus parity; odd parity gives an odd count.
  - On mismatch, the RX side sets `rx_parity_err`.
- **Undefined:**
  - Both ports are absent and no parity bit is sent or expected.
  - `rx_parity_err` is tied to 0.

## Test plan
Common setup: `DATA_W=8`, `OVS=16`, `baud_div=0`, giving `T=16`.

- **Reset:** assert `PRESETn=0` mid-TX frame → `Tx=1` and `tx_ready=1` immediately; `rx_valid=0`.
- **TX format:** `0xA5` accepted at cycle 0, `stop2=0` → `Tx` is low for cycles 1–16, then bits 1,0,1,0,0,1,0,1, then high. `tx_ready` is 1 at cycle 160. A back-to-back `0x5A` starts its start bit at cycle 161.
- **Loopback RX:** `Tx` tied to `RX`, send `0x3C` → `rx_valid` rises 155 cycles after the `Tx` falling edge, with `rx_data=0x3C` and all flags 0. A 3-cycle low glitch produces no `rx_valid`.
- **Frame error:** drive a frame carrying `0x00` with the stop bit low → `rx_valid=1`, `rx_frame_err=1`, `rx_data=0x00`.
- **Overrun:** send `0x11` then `0x22` with `rx_ready=0` → a single `rx_overrun` pulse at the second commit. `rx_data` stays `0x11` until it is accepted.
- **Parity (macro defined):** `parity_en=1`, `parity_odd=1`, send `0x01` → parity bit is 0. Injecting a flipped parity bit gives `rx_parity_err=1`.
